// File: rtl/key_disp_pkg.sv
// Shared types and 7-segment constants for the key counter / BCD display path.
package key_disp_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low gfedcba patterns for 0..9.
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_DIGIT[0];
      4'd1:    s = SEG_DIGIT[1];
      4'd2:    s = SEG_DIGIT[2];
      4'd3:    s = SEG_DIGIT[3];
      4'd4:    s = SEG_DIGIT[4];
      4'd5:    s = SEG_DIGIT[5];
      4'd6:    s = SEG_DIGIT[6];
      4'd7:    s = SEG_DIGIT[7];
      4'd8:    s = SEG_DIGIT[8];
      4'd9:    s = SEG_DIGIT[9];
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stable-level debounce for one active-low key.
// press pulses for one cycle when the debounced level falls; level is the debounced key.
module key_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press,
  output logic level
);

  localparam int CW = $clog2(DEB_CYCLES);

  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 2");
  end

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        cnt_d   = '0;
        lvl_d   = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      // any return to the accepted level restarts the stability window
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      lvl_q   <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
  assign level = lvl_q;

endmodule

// File: rtl/key_counter_bcd_disp.sv
// Debounced up/down key counter with sequential double-dabble BCD conversion and
// 7-segment drive; a count change publishes bcd/seg CNT_W+2 edges later.
module key_counter_bcd_disp
  import key_disp_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DIGITS     = 5,
  parameter int DEB_CYCLES = 1000000,
  parameter int WRAP       = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_inc_n,
  input  logic                  key_dec_n,
  input  logic                  clr,
  output logic [CNT_W-1:0]      count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  busy,
  output logic                  valid
);

  localparam int BW = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_width
    $error("CNT_W must be in 2..32");
  end
  if (pow10(DIGITS) <= (64'd1 << CNT_W) - 64'd1) begin : g_bad_digits
    $error("DIGITS too small for CNT_W");
  end

  // Blanking walks from the top digit down; digit 0 is always shown.
  function automatic logic [7*DIGITS-1:0] disp(input logic [4*DIGITS-1:0] b);
    logic [7*DIGITS-1:0] r;
    logic                shown;
    logic [3:0]          nib;
    r     = '0;
    shown = (BLANK_LZ == 0);
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = b[4*i +: 4];
      if (nib != 4'd0 || i == 0) shown = 1'b1;
      r[7*i +: 7] = shown ? bcd_to_seg(nib) : SEG_BLANK;
    end
    return r;
  endfunction

  localparam logic [7*DIGITS-1:0] SEG_RST = disp('0);

  logic inc_p, dec_p;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_inc_n),
    .press (inc_p),
    .level ()
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
    .clk   (clk),
    .rst   (rst),
    .key_n (key_dec_n),
    .press (dec_p),
    .level ()
  );

  logic [CNT_W-1:0]    count_q, count_d;
  state_e              state_q, state_d;
  logic                pend_q, pend_d;
  logic [CNT_W-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] sh_q, sh_d, adj;
  logic [BW-1:0]       bitc_q, bitc_d;
  logic [4*DIGITS-1:0] bcd_q;
  logic [7*DIGITS-1:0] seg_q, seg_new;
  logic                valid_q, valid_d;
  logic                chg, pub;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc_p && !dec_p) begin
      if (count_q == CNT_MAX) count_d = (WRAP != 0) ? '0 : CNT_MAX;
      else                    count_d = count_q + 1'b1;
    end else if (dec_p && !inc_p) begin
      if (count_q == '0) count_d = (WRAP != 0) ? CNT_MAX : '0;
      else               count_d = count_q - 1'b1;
    end
  end

  assign chg = (count_d != count_q);

  always_comb begin
    adj = sh_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = sh_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    bin_d   = bin_q;
    sh_d    = sh_q;
    bitc_d  = bitc_q;
    pub     = 1'b0;
    case (state_q)
      IDLE: begin
        if (chg || pend_q) state_d = LOAD;
      end
      LOAD: begin
        bin_d   = count_q;
        sh_d    = '0;
        pend_d  = 1'b0;
        bitc_d  = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {sh_d, bin_d} = {adj[4*DIGITS-2:0], bin_q, 1'b0};
        bitc_d        = bitc_q + 1'b1;
        if (bitc_q == BW'(CNT_W - 1)) state_d = DONE;
      end
      DONE: begin
        pub     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A change while converting is remembered, never aborts the running pass.
    if (chg && state_q != IDLE) pend_d = 1'b1;
  end

  always_comb begin
    valid_d = valid_q;
    if (chg)                 valid_d = 1'b0;
    else if (pub && !pend_q) valid_d = 1'b1;
  end

  assign seg_new = disp(sh_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      state_q <= IDLE;
      pend_q  <= 1'b0;
      bin_q   <= '0;
      sh_q    <= '0;
      bitc_q  <= '0;
      bcd_q   <= '0;
      seg_q   <= SEG_RST;
      valid_q <= 1'b1;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      pend_q  <= pend_d;
      bin_q   <= bin_d;
      sh_q    <= sh_d;
      bitc_q  <= bitc_d;
      valid_q <= valid_d;
      if (pub) begin
        bcd_q <= sh_q;
        seg_q <= seg_new;
      end
    end
  end

  assign count = count_q;
  assign bcd   = bcd_q;
  assign seg   = seg_q;
  assign busy  = (state_q == LOAD) || (state_q == SHIFT);
  assign valid = valid_q;

endmodule

// File: tb/tb_key_counter_bcd_disp.sv
// Bench for key_counter_bcd_disp: one wrapping/blanking instance and one saturating/unblanked one.
module tb_key_counter_bcd_disp;

  logic        clk = 1'b0;
  logic        rst, kin, kdn, clr;
  logic [7:0]  cnt_a, cnt_b;
  logic [11:0] bcd_a, bcd_b;
  logic [20:0] seg_a, seg_b;
  logic        busy_a, busy_b, valid_a, valid_b;

  int checks = 0;
  int errors = 0;
  int ma = 0;
  int mb = 0;

  logic [6:0] segt [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  key_counter_bcd_disp #(.CNT_W(8), .DIGITS(3), .DEB_CYCLES(4), .WRAP(1), .BLANK_LZ(1)) dut_a (
    .clk(clk), .rst(rst), .key_inc_n(kin), .key_dec_n(kdn), .clr(clr),
    .count(cnt_a), .bcd(bcd_a), .seg(seg_a), .busy(busy_a), .valid(valid_a));

  key_counter_bcd_disp #(.CNT_W(8), .DIGITS(3), .DEB_CYCLES(4), .WRAP(0), .BLANK_LZ(0)) dut_b (
    .clk(clk), .rst(rst), .key_inc_n(kin), .key_dec_n(kdn), .clr(clr),
    .count(cnt_b), .bcd(bcd_b), .seg(seg_b), .busy(busy_b), .valid(valid_b));

  function automatic int step(input int v, input int d, input bit wrap);
    int n;
    n = v + d;
    if (n > 255) return wrap ? 0 : 255;
    if (n < 0)   return wrap ? 255 : 0;
    return n;
  endfunction

  function automatic logic [11:0] e_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [20:0] e_seg(input int v, input bit blank);
    int h, t, o;
    logic [6:0] sh, st;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    sh = (blank && h == 0) ? 7'h7F : segt[h];
    st = (blank && h == 0 && t == 0) ? 7'h7F : segt[t];
    return {sh, st, segt[o]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cnt_a"}, 32'(cnt_a), 32'(ma));
    check({tag, ".cnt_b"}, 32'(cnt_b), 32'(mb));
    check({tag, ".bcd_a"}, 32'(bcd_a), 32'(e_bcd(ma)));
    check({tag, ".bcd_b"}, 32'(bcd_b), 32'(e_bcd(mb)));
    check({tag, ".seg_a"}, 32'(seg_a), 32'(e_seg(ma, 1'b1)));
    check({tag, ".seg_b"}, 32'(seg_b), 32'(e_seg(mb, 1'b0)));
    check({tag, ".valid"}, 32'({valid_a, valid_b}), 32'd3);
    check({tag, ".busy"},  32'({busy_a, busy_b}), 32'd0);
  endtask

  task automatic settle(input string tag);
    int n;
    n = 0;
    while (!(valid_a === 1'b1 && valid_b === 1'b1 && busy_a === 1'b0 && busy_b === 1'b0) && n < 60) begin
      tick();
      n++;
    end
    check({tag, ".settle"}, 32'(n < 60), 32'd1);
  endtask

  task automatic press(input bit i, input bit d, input int lo);
    kin = ~i;
    kdn = ~d;
    repeat (lo) tick();
    kin = 1'b1;
    kdn = 1'b1;
    repeat (9) tick();
  endtask

  task automatic do_inc(input int lo);
    press(1'b1, 1'b0, lo);
    ma = step(ma, 1, 1'b1);
    mb = step(mb, 1, 1'b0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ma = 0;
    mb = 0;
  endtask

  initial begin
    rst = 1'b1; kin = 1'b1; kdn = 1'b1; clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_all("reset");
    check("reset.seg_a_lit", 32'(seg_a), 32'h1FFFC0);

    // Short lows and bounces never reach the stability window.
    kin = 1'b0; repeat (3) tick(); kin = 1'b1; tick();
    kin = 1'b0; repeat (3) tick(); kin = 1'b1; repeat (10) tick();
    check_all("glitch");

    // Exact latency: event at edge 7 after the drive, publication 10 edges later.
    kin = 1'b0;
    repeat (6) tick();
    check("lat.before", 32'(cnt_a), 32'd0);
    kin = 1'b1;
    tick();
    ma = 1; mb = 1;
    check("lat.count", 32'(cnt_a), 32'd1);
    check("lat.valid_drop", 32'(valid_a), 32'd0);
    check("lat.busy", 32'(busy_a), 32'd1);
    repeat (9) tick();
    check("lat.bcd_old", 32'(bcd_a), 32'h000);
    tick();
    check("lat.bcd_new", 32'(bcd_a), 32'h001);
    check("lat.valid_up", 32'(valid_a), 32'd1);
    repeat (8) tick();
    check_all("first");

    for (int k = 2; k <= 255; k++) begin
      do_inc(6);
      check("ramp.cnt_a", 32'(cnt_a), 32'(ma));
    end
    settle("r255");
    check_all("r255");

    do_inc(5);
    settle("wrap_up");
    check_all("wrap_up");

    press(1'b0, 1'b1, 7);
    ma = step(ma, -1, 1'b1);
    mb = step(mb, -1, 1'b0);
    settle("wrap_dn");
    check_all("wrap_dn");
    check("wrap_dn.seg_lit", 32'(seg_a), 32'({7'h24, 7'h12, 7'h12}));

    do_clr();
    settle("clr1");
    for (int k = 0; k < 100; k++) do_inc(6);
    settle("r100");
    check_all("r100");

    // Decrement to 99, then land an increment in the 4th SHIFT cycle of that conversion.
    kdn = 1'b0;
    repeat (5) tick();
    kin = 1'b0;
    tick();
    kdn = 1'b1;
    tick();
    check("inj.cnt99", 32'(cnt_a), 32'd99);
    check("inj.busy", 32'(busy_a), 32'd1);
    repeat (4) tick();
    kin = 1'b1;
    tick();
    check("inj.cnt100", 32'({cnt_a, cnt_b}), 32'h6464);
    repeat (4) tick();
    check("inj.valid_pre", 32'(valid_a), 32'd0);
    tick();
    check("inj.stale_a", 32'(bcd_a), 32'h099);
    check("inj.stale_b", 32'(bcd_b), 32'h099);
    check("inj.stale_valid", 32'({valid_a, valid_b}), 32'd0);
    repeat (10) tick();
    check("inj.restart_wait", 32'(valid_a), 32'd0);
    tick();
    check("inj.fresh_a", 32'(bcd_a), 32'h100);
    check("inj.fresh_valid", 32'({valid_a, valid_b}), 32'd3);
    ma = 100; mb = 100;
    repeat (10) tick();
    do_inc(6);
    settle("r101");
    check_all("r101");

    do_clr();
    settle("clr2");
    for (int k = 0; k < 42; k++) do_inc(5);
    settle("r42");
    press(1'b1, 1'b1, 6);
    check_all("both");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ma = 0; mb = 0;
    check("clr42.count", 32'(cnt_a), 32'd0);
    check("clr42.valid", 32'(valid_a), 32'd0);
    check("clr42.busy", 32'(busy_a), 32'd1);
    settle("clr42");
    check_all("clr42");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr0.nochange", 32'({valid_a, busy_a}), 32'd2);

    for (int k = 0; k < 30; k++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 3) begin
        do_inc(int'($urandom_range(4, 9)));
      end else if (op <= 6) begin
        press(1'b0, 1'b1, int'($urandom_range(4, 9)));
        ma = step(ma, -1, 1'b1);
        mb = step(mb, -1, 1'b0);
      end else if (op == 7) begin
        press(1'b1, 1'b1, int'($urandom_range(4, 9)));
      end else if (op == 8) begin
        do_clr();
      end else begin
        press(1'(op & 1), 1'(~op & 1), int'($urandom_range(1, 3)));
      end
      settle("rand");
      check_all("rand");
    end

    // Reset mid-SHIFT restores every output without waiting for a clock edge.
    kin = 1'b0;
    repeat (6) tick();
    kin = 1'b1;
    repeat (4) tick();
    check("rst.busy", 32'(busy_a), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    ma = 0; mb = 0;
    check_all("rst_async");
    repeat (3) tick();
    rst = 1'b0;
    repeat (12) tick();
    check_all("rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
